dsc_mul_seq: RTL and testbench
==============================

# dsc_mul_seq

Single-clock sequencer for the 3-input deterministic stochastic-computing (DSC) multiplier. It accepts one operand triple per transaction over a valid/ready handshake. It generates the three nested unary bit-streams with enable-chained counters rather than ripple clocks, ANDs them, and accumulates the product count into a 3·SNG_WIDTH result. The run ends early once the outermost stream (C) goes permanently low, so one operation costs c·2^(2·SNG_WIDTH) stream cycles instead of 2^(3·SNG_WIDTH).

## Interface
- SNG_WIDTH, 10, operand width N; counters and streams are N bits wide.
- clk  in  1  single clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand triple is valid.
- in_ready  out  1  block accepts operands; high only in IDLE.
- a, b, c  in  N each  unsigned operands; sampled on the in_valid & in_ready cycle.
- abort  in  1  cancels a RUN in progress; ignored in other states.
- out_valid  out  1  z is valid; high only in DONE.
- out_ready  in  1  consumer takes z.
- z  out  3N  product count; equals a·b·c.
- busy  out  1  high in RUN.
- sn_a, sn_b, sn_c, sn_mul  out  1 each  current stream bits, for observation; forced 0 outside RUN.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: register a_q, b_q, c_q, clear z and clear counters ctr_a, ctr_b, ctr_c to 0.
  - If any operand is 0, go to DONE with z=0. Otherwise go to RUN.
- **RUN, every cycle:**
  - sn_a=(ctr_a<a_q), sn_b=(ctr_b<b_q), sn_c=(ctr_c<c_q), sn_mul=sn_a&sn_b&sn_c.
  - z += sn_mul.
  - ctr_a increments every cycle.
  - ctr_b increments when ctr_a wraps from 2^N−1 to 0.
  - ctr_c increments when both ctr_a and ctr_b are at 2^N−1.
  - Counters wrap modulo 2^N.
- **Early shutoff:** on the cycle where ctr_a and ctr_b are both at 2^N−1 and ctr_c==c_q−1, the increment is the last one and the next state is DONE. Later stream positions would contribute 0.
  - Because c_q ≤ 2^N−1, ctr_c never wraps.
- **Abort:** abort in RUN sends the block to IDLE next cycle. z is cleared, out_valid is never raised and the operands are discarded.
- **DONE:**
  - out_valid=1; z is held stable.
  - On out_ready, go to IDLE next cycle.
  - in_ready stays 0 in DONE, so an accept can never coincide with the DONE-exit cycle.
- **Arithmetic:** the z accumulator is 3N bits and cannot overflow, since the maximum is (2^N−1)^3 < 2^(3N).
- **Reset** (at any time, including mid-RUN or DONE):
  - State goes to IDLE; z=0, counters=0, operand registers=0.
  - in_ready=1, out_valid=0, busy=0, all sn_* = 0.

## Timing
- Accept at cycle T:
  - Non-zero operands: RUN occupies cycles T+1 … T+c·2^(2N). The first stream cycle has all counters at 0.
  - The final z is visible and out_valid=1 at T+c·2^(2N)+1.
  - Latency from accept to out_valid is c·4^N+1 cycles.
- Zero operand: out_valid=1 at T+1, z=0.
- out_valid & out_ready at cycle D: IDLE and in_ready=1 at D+1. The earliest next accept is D+1.
- z is registered, so it updates the cycle after the sn_mul it counts.
- in_valid during RUN or DONE is ignored; the operands must stay presented until accepted.
- abort and rst asserted together: rst wins, with the same outcome.
- abort on the last RUN cycle: abort wins, so the block goes to IDLE and DONE is not entered.

## Test plan
- **Basic product:** SNG_WIDTH=3, a=5, b=3, c=2, out_ready=1 → out_valid exactly 129 cycles after the accept, z=30, busy high for 128 cycles.
- **Full scale:** SNG_WIDTH=3, a=b=c=7 → z=343, latency 449. Default SNG_WIDTH=10 with a=1, b=1, c=1 → z=1, latency 1,048,577.
- **Zero shortcut:** a=0, b=7, c=7, then separately a=7, b=7, c=0 → out_valid at T+1, z=0, busy never asserted.
- **Backpressure:** SNG_WIDTH=3, a=b=c=2, out_ready low for 10 cycles after DONE → z=8 held stable, in_ready=0 throughout. After out_ready, the second triple (1,1,1) is accepted and returns z=1.
- **Abort and reset mid-run:**
  - abort at RUN cycle 40 → IDLE next cycle, no out_valid, z=0.
  - rst mid-RUN → all outputs at their reset values next cycle.
  - A following op (3,3,3) returns z=27.
- **Stream check:** N=3, a=5, b=3, c=2 → sn_a pattern 11111000 repeating, and sn_mul total over the run is 30.

Source files
------------

// File: rtl/dsc_mul_seq.sv
// -----------------------------------------------------------------------------
// dsc_mul_seq
// Sequencer for a 3-input deterministic stochastic-computing multiplier.
// One operand triple is taken per transaction over valid/ready. Three nested
// unary streams are produced from enable-chained counters (A innermost,
// C outermost). The streams are ANDed, and the product count is accumulated
// into z. The run stops as soon as stream C has gone permanently low, so an
// operation lasts c * 2^(2N) stream cycles.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand triple valid
//   in_ready   out  block accepts operands (IDLE only)
//   a, b, c    in   N-bit unsigned operands
//   abort      in   cancel a run in progress (ignored outside RUN)
//   out_valid  out  z valid (DONE only)
//   out_ready  in   consumer takes z
//   z          out  3N-bit product count, a*b*c
//   busy       out  high in RUN
//   sn_a/b/c   out  current stream bits, 0 outside RUN
//   sn_mul     out  AND of the three stream bits, 0 outside RUN
// -----------------------------------------------------------------------------
module dsc_mul_seq #(
    parameter int SNG_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SNG_WIDTH-1:0]     a,
    input  logic [SNG_WIDTH-1:0]     b,
    input  logic [SNG_WIDTH-1:0]     c,
    input  logic                     abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3*SNG_WIDTH-1:0]   z,
    output logic                     busy,
    output logic                     sn_a,
    output logic                     sn_b,
    output logic                     sn_c,
    output logic                     sn_mul
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [SNG_WIDTH-1:0]   CTR_ZERO = {SNG_WIDTH{1'b0}};
    localparam logic [SNG_WIDTH-1:0]   CTR_ONE  = {{(SNG_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3*SNG_WIDTH-1:0] Z_ZERO   = {(3*SNG_WIDTH){1'b0}};

    logic [1:0]             state_r;
    logic [1:0]             state_nx_s;
    logic [SNG_WIDTH-1:0]   a_q_r;
    logic [SNG_WIDTH-1:0]   b_q_r;
    logic [SNG_WIDTH-1:0]   c_q_r;
    logic [SNG_WIDTH-1:0]   ctr_a_r;
    logic [SNG_WIDTH-1:0]   ctr_b_r;
    logic [SNG_WIDTH-1:0]   ctr_c_r;
    logic [3*SNG_WIDTH-1:0] z_r;

    logic                   a_max_s;
    logic                   b_max_s;
    logic                   last_s;
    logic                   zero_op_s;
    logic                   raw_a_s;
    logic                   raw_b_s;
    logic                   raw_c_s;
    logic                   raw_mul_s;

    // Stream comparators, counter-wrap detection and end-of-run detection.
    always_comb begin
        a_max_s   = (ctr_a_r == {SNG_WIDTH{1'b1}});
        b_max_s   = (ctr_b_r == {SNG_WIDTH{1'b1}});
        // Last useful stream cycle: inner counters about to wrap and C on its
        // final high position. c_q_r is non-zero whenever RUN is entered.
        last_s    = a_max_s & b_max_s & (ctr_c_r == (c_q_r - CTR_ONE));
        zero_op_s = (a == CTR_ZERO) | (b == CTR_ZERO) | (c == CTR_ZERO);
        raw_a_s   = (ctr_a_r < a_q_r);
        raw_b_s   = (ctr_b_r < b_q_r);
        raw_c_s   = (ctr_c_r < c_q_r);
        raw_mul_s = raw_a_s & raw_b_s & raw_c_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort takes priority over the end-of-run transition.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (zero_op_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state; stream bits gated to RUN.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sn_a      = 1'b0;
        sn_b      = 1'b0;
        sn_c      = 1'b0;
        sn_mul    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_RUN: begin
                busy   = 1'b1;
                sn_a   = raw_a_s;
                sn_b   = raw_b_s;
                sn_c   = raw_c_s;
                sn_mul = raw_mul_s;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand capture, enable-chained stream counters and product accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q_r   <= CTR_ZERO;
            b_q_r   <= CTR_ZERO;
            c_q_r   <= CTR_ZERO;
            ctr_a_r <= CTR_ZERO;
            ctr_b_r <= CTR_ZERO;
            ctr_c_r <= CTR_ZERO;
            z_r     <= Z_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q_r   <= a;
                        b_q_r   <= b;
                        c_q_r   <= c;
                        ctr_a_r <= CTR_ZERO;
                        ctr_b_r <= CTR_ZERO;
                        ctr_c_r <= CTR_ZERO;
                        z_r     <= Z_ZERO;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        a_q_r   <= CTR_ZERO;
                        b_q_r   <= CTR_ZERO;
                        c_q_r   <= CTR_ZERO;
                        ctr_a_r <= CTR_ZERO;
                        ctr_b_r <= CTR_ZERO;
                        ctr_c_r <= CTR_ZERO;
                        z_r     <= Z_ZERO;
                    end else begin
                        z_r     <= z_r + {{(3*SNG_WIDTH-1){1'b0}}, raw_mul_s};
                        ctr_a_r <= ctr_a_r + CTR_ONE;
                        if (a_max_s) begin
                            ctr_b_r <= ctr_b_r + CTR_ONE;
                        end
                        // c_q_r never exceeds 2^N-1, so ctr_c_r cannot wrap.
                        if (a_max_s && b_max_s) begin
                            ctr_c_r <= ctr_c_r + CTR_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    z_r <= z_r;
                end
                default: begin
                    ctr_a_r <= CTR_ZERO;
                    ctr_b_r <= CTR_ZERO;
                    ctr_c_r <= CTR_ZERO;
                    z_r     <= Z_ZERO;
                end
            endcase
        end
    end

    assign z = z_r;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_dsc_mul_seq
// Self-checking bench for dsc_mul_seq at SNG_WIDTH=3. Expected products,
// latencies and stream bits come from a stream-position model: run cycle k
// maps to positions (k mod 8, (k/8) mod 8, k/64) of streams A, B, C.
// -----------------------------------------------------------------------------
module tb_dsc_mul_seq;

    localparam int N   = 3;
    localparam int L   = 1 << N;
    localparam int BUD = 1000;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [3*N-1:0] z;
    logic           busy;
    logic           sn_a;
    logic           sn_b;
    logic           sn_c;
    logic           sn_mul;

    int total;
    int bad;

    dsc_mul_seq #(.SNG_WIDTH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy),
        .sn_a      (sn_a),
        .sn_b      (sn_b),
        .sn_c      (sn_c),
        .sn_mul    (sn_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || z !== 9'd0 ||
            {sn_a, sn_b, sn_c, sn_mul} !== 4'b0000) begin
            bad++;
            $display("FAIL %s: in_ready=%b out_valid=%b busy=%b z=%0d sn=%b%b%b%b, required 1 0 0 0 0000",
                     name, in_ready, out_valid, busy, z, sn_a, sn_b, sn_c, sn_mul);
        end
    endtask

    // Present a triple in IDLE; returns after the accepting edge.
    task automatic accept(input int av, input int bv, input int cv);
        a        = N'(av);
        b        = N'(bv);
        c        = N'(cv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full transaction with reference checks. hold = cycles out_ready stays low in DONE.
    task automatic run_op(input string name, input int av, input int bv, input int cv, input int hold);
        int             n;
        int             k;
        int             busy_cnt;
        int             mul_cnt;
        int             strm_err;
        int             exp_lat;
        int             exp_run;
        logic [3*N-1:0] exp_z;
        logic           ea;
        logic           eb;
        logic           ec;
        exp_z   = 9'(av * bv * cv);
        exp_run = (av == 0 || bv == 0 || cv == 0) ? 0 : cv * L * L;
        exp_lat = exp_run + 1;
        busy_cnt = 0;
        mul_cnt  = 0;
        strm_err = 0;
        out_ready = (hold == 0);
        accept(av, bv, cv);
        n = 1;
        k = 0;
        while (!out_valid && n < BUD) begin
            if (busy) begin
                busy_cnt++;
                ea = (k % L) < av;
                eb = ((k / L) % L) < bv;
                ec = (k / (L * L)) < cv;
                if (sn_a !== ea || sn_b !== eb || sn_c !== ec || sn_mul !== (ea & eb & ec)) begin
                    strm_err++;
                end
                if (sn_mul) begin
                    mul_cnt++;
                end
                k++;
            end
            tick();
            n++;
        end
        total++;
        if (n != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d, required %0d", name, n, exp_lat);
        end
        total++;
        if (z !== exp_z) begin
            bad++;
            $display("FAIL %s z: got %0d, required %0d", name, z, exp_z);
        end
        total++;
        if (busy_cnt != exp_run || strm_err != 0 || mul_cnt != int'(exp_z)) begin
            bad++;
            $display("FAIL %s stream: busy=%0d (req %0d) stream_errs=%0d sn_mul_total=%0d (req %0d)",
                     name, busy_cnt, exp_run, strm_err, mul_cnt, exp_z);
        end
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                total++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== exp_z) begin
                    bad++;
                    $display("FAIL %s hold%0d: out_valid=%b in_ready=%b z=%0d, required 1 0 %0d",
                             name, h, out_valid, in_ready, z, exp_z);
                end
            end
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s release: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_basic();
        run_op("basic_5_3_2", 5, 3, 2, 0);
        run_op("full_7_7_7", 7, 7, 7, 0);
    endtask

    task automatic test_zero();
        run_op("zero_a", 0, 7, 7, 0);
        run_op("zero_c", 7, 7, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_op("backpressure_2_2_2", 2, 2, 2, 10);
        run_op("after_bp_1_1_1", 1, 1, 1, 0);
    endtask

    task automatic test_abort();
        accept(3, 3, 3);
        for (int i = 1; i < 40; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_mid");
        for (int i = 0; i < 5; i++) tick();
        check_idle("abort_stays_idle");
        // Abort on the final RUN cycle of (1,1,1): run covers 64 cycles.
        accept(1, 1, 1);
        for (int i = 1; i < L * L; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_last_cycle");
        run_op("after_abort_3_3_3", 3, 3, 3, 0);
    endtask

    task automatic test_rst_midrun();
        accept(7, 7, 7);
        for (int i = 0; i < 50; i++) tick();
        rst   = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        abort = 1'b0;
        check_idle("rst_midrun");
        run_op("after_rst_3_3_3", 3, 3, 3, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rand%0d", i), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_abort();
        test_rst_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
